acq_window_gate: RTL and testbench
==================================

Name: acq_window_gate

Overview:
- Upstream stage of the averager in the readout chain.
- Watches a trigger, waits a programmable delay, then forwards exactly N consecutive ADC samples as a valid-qualified burst into the averager's i_valid/i_data.
- Owns the averaging-length configuration and issues the averager's command (i_avg_cmd_valid/i_avg_cmd_data), so the burst length and the averaging length always match.

Parameters:
INT_IN_DATA_WIDTH, 14, ADC sample width (signed)
INT_MAX_AVERAGE_BY, 10, maximum burst length N; must match the averager
INT_MAX_DELAY, 1024, maximum trigger-to-capture delay in cycles (exclusive)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_trigger  in  1  trigger level; rising edge starts a window
i_adc_data  in  INT_IN_DATA_WIDTH  signed ADC sample, valid every cycle
i_cfg_valid  in  1  configuration strobe
i_cfg_delay  in  $clog2(INT_MAX_DELAY)  delay D in cycles
i_cfg_length  in  $clog2(INT_MAX_AVERAGE_BY)  burst length minus one (L = N-1)
o_valid  out  1  sample valid, to averager i_valid
o_data  out  INT_IN_DATA_WIDTH  signed sample, to averager i_data
o_avg_cmd_valid  out  1  one-cycle command pulse, to averager i_avg_cmd_valid
o_avg_cmd_data  out  $clog2(INT_MAX_AVERAGE_BY)  L after clamping, to averager i_avg_cmd_data
o_busy  out  1  high in DELAY or CAPTURE
o_trigger_missed  out  1  one-cycle pulse when a trigger edge is ignored
o_missed_count  out  16  saturating count of ignored triggers

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all outputs = 0.
  - Configuration returns to D = 0 and L = INT_MAX_AVERAGE_BY-1.
  - Trigger edge register = 0. No command pulse is issued on reset exit.
- Edge detect: trig_prev <= i_trigger. An edge is i_trigger & ~trig_prev, evaluated every cycle in all states.
- State machine: IDLE, DELAY, CAPTURE.
- IDLE:
  - i_cfg_valid = 1: latch D. Latch L clamped to min(i_cfg_length, INT_MAX_AVERAGE_BY-1). Next cycle, o_avg_cmd_valid = 1 and o_avg_cmd_data = clamped L, for exactly one cycle. o_missed_count clears to 0.
  - A trigger edge in the same cycle as i_cfg_valid: configuration wins and the edge counts as missed.
  - An edge with no i_cfg_valid: go to DELAY if D > 0, otherwise go directly to CAPTURE.
  - A trigger edge in the cycle o_avg_cmd_valid is high is accepted normally. The averager resets its counter that cycle and the first sample arrives at least one cycle later.
- DELAY: count D cycles, so D cycles are spent in DELAY, then go to CAPTURE.
- CAPTURE:
  - Each cycle, register i_adc_data into o_data and assert o_valid the next cycle.
  - After L+1 samples, go to IDLE.
  - o_valid is contiguous: exactly L+1 consecutive cycles per window.
- Latency: with the edge sampled in cycle t, samples are taken at cycles t+1+D .. t+1+D+L. They appear on o_data/o_valid at cycles t+2+D .. t+2+D+L.
- When o_valid = 0, o_data holds its last value. The downstream block must ignore o_data when o_valid is low.
- Busy:
  - o_busy = 1 in DELAY and CAPTURE.
  - An edge while busy, including on the last CAPTURE cycle, produces a one-cycle o_trigger_missed pulse next cycle and increments o_missed_count, saturating at 0xFFFF.
  - The window in progress is unaffected.
- i_cfg_valid while busy is ignored entirely: no latch, no command pulse.
- A reset asserted mid-window aborts it immediately. o_valid goes 0 in the cycle after reset is sampled; no partial-burst completion.
- A trigger held high produces only one edge. A new window needs the trigger to go low and then high again.
- Widths: counters are sized $clog2(INT_MAX_DELAY) and $clog2(INT_MAX_AVERAGE_BY). Data passes through unmodified; no sign extension.

Test Plan:
- Reset, then trigger edge at cycle 10, D = 0, L = 9 -> o_valid high for cycles 12..21 (10 cycles); o_data equals the ramp input sampled at cycles 11..20; averager output valid once.
- cfg D = 5, L = 3 in IDLE -> one o_avg_cmd_valid pulse with data 3 next cycle; edge at t -> 4 valid samples at t+7..t+10.
- cfg L = 15 with INT_MAX_AVERAGE_BY = 10 -> o_avg_cmd_data = 9; the burst is 10 samples.
- Second edge during DELAY and a third on the last CAPTURE cycle -> two o_trigger_missed pulses, o_missed_count = 2, first burst intact; a subsequent cfg clears the count to 0.
- i_cfg_valid and edge in the same IDLE cycle -> command pulse issued, no window starts, missed = 1. i_cfg_valid while busy -> no command pulse, configuration unchanged.
- Reset asserted during the 3rd capture cycle of L = 9 -> o_valid low the following cycle, state IDLE, D = 0, L = 9; a new edge produces a full 10-sample burst.

Source files
------------

// File: rtl/acq_window_gate.sv
// Trigger-qualified acquisition window: delays after a trigger edge, then
// forwards a fixed-length sample burst and issues the matching averager command.
module acq_window_gate #(
  parameter  int INT_IN_DATA_WIDTH  = 14,
  parameter  int INT_MAX_AVERAGE_BY = 10,
  parameter  int INT_MAX_DELAY      = 1024,
  localparam int DW = $clog2(INT_MAX_DELAY),
  localparam int LW = $clog2(INT_MAX_AVERAGE_BY)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_trigger,
  input  logic [INT_IN_DATA_WIDTH-1:0] i_adc_data,
  input  logic                         i_cfg_valid,
  input  logic [DW-1:0]                i_cfg_delay,
  input  logic [LW-1:0]                i_cfg_length,
  output logic                         o_valid,
  output logic [INT_IN_DATA_WIDTH-1:0] o_data,
  output logic                         o_avg_cmd_valid,
  output logic [LW-1:0]                o_avg_cmd_data,
  output logic                         o_busy,
  output logic                         o_trigger_missed,
  output logic [15:0]                  o_missed_count
);

  localparam logic [LW-1:0] LMAX = LW'(INT_MAX_AVERAGE_BY - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    CAPTURE
  } state_e;

  state_e                         state_q, state_d;
  logic                           trig_prev_q;
  logic [DW-1:0]                  cfg_delay_q, cfg_delay_d;
  logic [LW-1:0]                  cfg_len_q, cfg_len_d;
  logic [DW-1:0]                  dly_cnt_q, dly_cnt_d;
  logic [LW-1:0]                  cap_cnt_q, cap_cnt_d;
  logic                           valid_q, valid_d;
  logic [INT_IN_DATA_WIDTH-1:0]   data_q, data_d;
  logic                           cmd_valid_q, cmd_valid_d;
  logic [LW-1:0]                  cmd_data_q, cmd_data_d;
  logic                           missed_q, missed_d;
  logic [15:0]                    missed_cnt_q, missed_cnt_d;
  logic                           trig_edge;
  logic                           busy;
  logic [LW-1:0]                  len_clamped;

  assign trig_edge   = i_trigger & ~trig_prev_q;
  assign busy        = (state_q != IDLE);
  assign len_clamped = (i_cfg_length > LMAX) ? LMAX : i_cfg_length;

  always_comb begin
    state_d      = state_q;
    cfg_delay_d  = cfg_delay_q;
    cfg_len_d    = cfg_len_q;
    dly_cnt_d    = dly_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    valid_d      = 1'b0;
    data_d       = data_q;
    cmd_valid_d  = 1'b0;
    cmd_data_d   = cmd_data_q;
    missed_d     = 1'b0;
    missed_cnt_d = missed_cnt_q;

    if (trig_edge && busy) begin
      missed_d = 1'b1;
      if (missed_cnt_q != 16'hFFFF) begin
        missed_cnt_d = missed_cnt_q + 16'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (i_cfg_valid) begin
          // A simultaneous edge loses to configuration and is the first miss
          cfg_delay_d  = i_cfg_delay;
          cfg_len_d    = len_clamped;
          cmd_valid_d  = 1'b1;
          cmd_data_d   = len_clamped;
          missed_d     = trig_edge;
          missed_cnt_d = {15'b0, trig_edge};
        end else if (trig_edge) begin
          dly_cnt_d = '0;
          cap_cnt_d = '0;
          state_d   = (cfg_delay_q != '0) ? DELAY : CAPTURE;
        end
      end
      DELAY: begin
        dly_cnt_d = dly_cnt_q + DW'(1);
        if (dly_cnt_q == cfg_delay_q - DW'(1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        valid_d   = 1'b1;
        data_d    = i_adc_data;
        cap_cnt_d = cap_cnt_q + LW'(1);
        if (cap_cnt_q == cfg_len_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      trig_prev_q  <= 1'b0;
      cfg_delay_q  <= '0;
      cfg_len_q    <= LMAX;
      dly_cnt_q    <= '0;
      cap_cnt_q    <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_data_q   <= '0;
      missed_q     <= 1'b0;
      missed_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      trig_prev_q  <= i_trigger;
      cfg_delay_q  <= cfg_delay_d;
      cfg_len_q    <= cfg_len_d;
      dly_cnt_q    <= dly_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_data_q   <= cmd_data_d;
      missed_q     <= missed_d;
      missed_cnt_q <= missed_cnt_d;
    end
  end

  assign o_valid          = valid_q;
  assign o_data           = data_q;
  assign o_avg_cmd_valid  = cmd_valid_q;
  assign o_avg_cmd_data   = cmd_data_q;
  assign o_busy           = busy;
  assign o_trigger_missed = missed_q;
  assign o_missed_count   = missed_cnt_q;

endmodule

// File: tb/tb_acq_window_gate.sv
// Directed bench for acq_window_gate: bursts, commands and missed
// triggers are predicted into scoreboards and compared cycle by cycle.
module tb_acq_window_gate;

  localparam int DWID = 14;
  localparam int MAXN = 10;
  localparam int MAXD = 1024;
  localparam int DLW  = $clog2(MAXD);
  localparam int LNW  = $clog2(MAXN);

  logic            clk = 1'b0;
  logic            rst;
  logic            i_trigger;
  logic [DWID-1:0] i_adc_data;
  logic            i_cfg_valid;
  logic [DLW-1:0]  i_cfg_delay;
  logic [LNW-1:0]  i_cfg_length;
  logic            o_valid;
  logic [DWID-1:0] o_data;
  logic            o_avg_cmd_valid;
  logic [LNW-1:0]  o_avg_cmd_data;
  logic            o_busy;
  logic            o_trigger_missed;
  logic [15:0]     o_missed_count;

  always #5 clk = ~clk;

  acq_window_gate #(
    .INT_IN_DATA_WIDTH (DWID),
    .INT_MAX_AVERAGE_BY(MAXN),
    .INT_MAX_DELAY     (MAXD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_trigger       (i_trigger),
    .i_adc_data      (i_adc_data),
    .i_cfg_valid     (i_cfg_valid),
    .i_cfg_delay     (i_cfg_delay),
    .i_cfg_length    (i_cfg_length),
    .o_valid         (o_valid),
    .o_data          (o_data),
    .o_avg_cmd_valid (o_avg_cmd_valid),
    .o_avg_cmd_data  (o_avg_cmd_data),
    .o_busy          (o_busy),
    .o_trigger_missed(o_trigger_missed),
    .o_missed_count  (o_missed_count)
  );

  typedef struct {
    int              cyc;
    logic [DWID-1:0] data;
  } exp_t;

  exp_t           sbq[$];
  int             miss_q[$];
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  int             exp_cmd_cyc = -1;
  logic [LNW-1:0] exp_cmd_data = '0;
  int             m_d;
  int             m_l;
  int             t;

  function automatic logic [DWID-1:0] ramp(int c);
    return DWID'(c * 613 + 8000);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs seen here belong to the new cycle
  task automatic tick();
    exp_t e;
    logic ev;
    logic em;
    @(posedge clk);
    cyc++;
    #1;
    ev = 1'b0;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e  = sbq.pop_front();
      ev = 1'b1;
    end
    chk("o_valid", 32'(o_valid), 32'(ev));
    if (ev) chk("o_data", 32'(o_data), 32'(e.data));
    chk("cmd_valid", 32'(o_avg_cmd_valid), 32'(cyc == exp_cmd_cyc));
    if (cyc == exp_cmd_cyc)
      chk("cmd_data", 32'(o_avg_cmd_data), 32'(exp_cmd_data));
    em = 1'b0;
    if (miss_q.size() > 0 && miss_q[0] == cyc) begin
      void'(miss_q.pop_front());
      em = 1'b1;
    end
    chk("missed", 32'(o_trigger_missed), 32'(em));
    i_adc_data = ramp(cyc);
  endtask

  task automatic push_burst(int te);
    exp_t e;
    for (int k = 0; k <= m_l; k++) begin
      e.cyc  = te + 2 + m_d + k;
      e.data = ramp(te + 1 + m_d + k);
      sbq.push_back(e);
    end
  endtask

  task automatic cfg(int d, int l, bit accept);
    i_cfg_valid  = 1'b1;
    i_cfg_delay  = DLW'(d);
    i_cfg_length = LNW'(l);
    if (accept) begin
      m_d          = d;
      m_l          = (l > MAXN - 1) ? MAXN - 1 : l;
      exp_cmd_cyc  = cyc + 1;
      exp_cmd_data = LNW'(m_l);
    end
    tick();
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    i_trigger    = 1'b0;
    i_cfg_valid  = 1'b0;
    i_cfg_delay  = '0;
    i_cfg_length = '0;
    i_adc_data   = ramp(0);
    m_d          = 0;
    m_l          = MAXN - 1;

    tick();
    tick();
    chk("rst_data", 32'(o_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_cmd_data", 32'(o_avg_cmd_data), 0);
    chk("rst_miss_cnt", 32'(o_missed_count), 0);
    rst = 1'b0;

    // Default config, trigger held high across the burst
    while (cyc < 10) tick();
    i_trigger = 1'b1;
    push_burst(cyc);
    tick();
    chk("busy_cap", 32'(o_busy), 1);
    while (cyc < 15) tick();
    i_trigger = 1'b0;
    while (cyc < 25) tick();
    chk("idle_busy", 32'(o_busy), 0);

    // D=5 L=3; edge lands in the command cycle
    cfg(5, 3, 1'b1);
    i_trigger = 1'b1;
    push_burst(cyc);
    tick();
    i_trigger = 1'b0;
    chk("busy_dly", 32'(o_busy), 1);
    repeat (15) tick();

    // Length clamp
    cfg(2, 15, 1'b1);
    tick();
    i_trigger = 1'b1;
    push_burst(cyc);
    tick();
    i_trigger = 1'b0;
    repeat (20) tick();

    // Edges during DELAY and on the last CAPTURE cycle
    t = cyc;
    i_trigger = 1'b1;
    push_burst(t);
    tick();
    i_trigger = 1'b0;
    tick();
    i_trigger = 1'b1;
    miss_q.push_back(cyc + 1);
    tick();
    i_trigger = 1'b0;
    while (cyc < t + 1 + m_d + m_l) tick();
    chk("busy_last", 32'(o_busy), 1);
    i_trigger = 1'b1;
    miss_q.push_back(cyc + 1);
    tick();
    chk("busy_end", 32'(o_busy), 0);
    tick();
    i_trigger = 1'b0;
    repeat (8) tick();
    chk("miss_cnt2", 32'(o_missed_count), 2);
    cfg(1, 4, 1'b1);
    chk("miss_clr", 32'(o_missed_count), 0);
    repeat (4) tick();

    // Config and edge in the same idle cycle
    i_trigger = 1'b1;
    miss_q.push_back(cyc + 1);
    cfg(3, 2, 1'b1);
    chk("cfgedge_busy", 32'(o_busy), 0);
    chk("cfgedge_cnt", 32'(o_missed_count), 1);
    i_trigger = 1'b0;
    repeat (10) tick();

    // Config while busy is dropped
    i_trigger = 1'b1;
    push_burst(cyc);
    tick();
    i_trigger = 1'b0;
    cfg(7, 6, 1'b0);
    repeat (12) tick();
    i_trigger = 1'b1;
    push_burst(cyc);
    tick();
    i_trigger = 1'b0;
    repeat (12) tick();

    // Reset in the third capture cycle
    cfg(4, 9, 1'b1);
    tick();
    t = cyc;
    i_trigger = 1'b1;
    push_burst(t);
    tick();
    i_trigger = 1'b0;
    while (cyc < t + 7) tick();
    rst = 1'b1;
    while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
    m_d = 0;
    m_l = MAXN - 1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_cmd_data", 32'(o_avg_cmd_data), 0);
    chk("abort_miss_cnt", 32'(o_missed_count), 0);
    repeat (3) tick();
    i_trigger = 1'b1;
    push_burst(cyc);
    tick();
    i_trigger = 1'b0;
    repeat (15) tick();

    chk("sb_empty", 32'(sbq.size()), 0);
    chk("miss_empty", 32'(miss_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
